// File: rtl/relu_mask_codec.sv
// relu_mask_codec: client-side mask codec for the masked 64-bit ReLU stage.
// Forward path masks each activation x with a fresh xorshift64 value g and
// emits (g, x - g). Return path subtracts the same g, popped in order from a
// mask FIFO, from each masked result relu(x) + g to recover relu(x).
module relu_mask_codec #(
  parameter int               WIDTH = 64,
  parameter int               DEPTH = 8,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // plaintext activations
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  // masked pair towards the garbled ReLU
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_mask,
  output logic [WIDTH-1:0]         m_masked,
  // masked ReLU results
  input  logic                     r_valid,
  output logic                     r_ready,
  input  logic [WIDTH-1:0]         r_data,
  // unmasked results
  output logic                     u_valid,
  input  logic                     u_ready,
  output logic [WIDTH-1:0]         u_data,
  // PRNG reseed
  input  logic                     seed_load,
  input  logic [WIDTH-1:0]         seed_data,
  // masks currently outstanding
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // xorshift64 step: s ^= s<<13; s ^= s>>7; s ^= s<<17
  function automatic logic [WIDTH-1:0] prng_advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] t;
    // NOTE: blocking assignments are correct here; this is a pure function
    // evaluated in order, not sequential state.
    t = s ^ (s << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic             r_m_valid;
  logic [WIDTH-1:0] r_m_mask;
  logic [WIDTH-1:0] r_m_masked;
  logic             r_u_valid;
  logic [WIDTH-1:0] r_u_data;

  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;
  logic [WIDTH-1:0] w_seed_value;

  // Handshakes: a full FIFO blocks pushes and an empty one blocks pops even
  // when the opposite operation happens in the same cycle (no bypass).
  assign in_ready     = (~r_m_valid | m_ready) & (r_count != FULL_CNT);
  assign r_ready      = (~r_u_valid | u_ready) & (r_count != '0);
  assign w_push       = in_valid & in_ready;
  assign w_pop        = r_valid & r_ready;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_seed_value = (seed_data == '0) ? SEED : seed_data;

  assign m_valid  = r_m_valid;
  assign m_mask   = r_m_mask;
  assign m_masked = r_m_masked;
  assign u_valid  = r_u_valid;
  assign u_data   = r_u_data;
  assign pending  = r_count;

  // PRNG state: a reseed wins over the advance caused by an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED;
    end else if (seed_load) begin
      r_state <= w_seed_value;
    end else if (w_push) begin
      r_state <= prng_advance(r_state);
    end
  end

  // Mask storage: the current mask is pushed on every forward accept.
  // NOTE: the storage array has no reset; pointers and count define which
  // entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_state;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

  // Forward output register: capture (g, x - g), hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid  <= 1'b0;
      r_m_mask   <= '0;
      r_m_masked <= '0;
    end else if (w_push) begin
      r_m_valid  <= 1'b1;
      r_m_mask   <= r_state;
      r_m_masked <= in_data - r_state;
    end else if (m_ready) begin
      r_m_valid  <= 1'b0;
    end
  end

  // Return output register: unmask with the oldest outstanding mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_u_valid <= 1'b0;
      r_u_data  <= '0;
    end else if (w_pop) begin
      r_u_valid <= 1'b1;
      r_u_data  <= r_data - w_head;
    end else if (u_ready) begin
      r_u_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_relu_mask_codec.sv
// tb_relu_mask_codec: directed scenarios plus randomized traffic, compared
// every cycle against a queue-based reference of the codec behaviour.
module tb_relu_mask_codec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [63:0] m_mask;
  logic [63:0] m_masked;
  logic        r_valid = 1'b0;
  logic        r_ready;
  logic [63:0] r_data = '0;
  logic        u_valid;
  logic        u_ready = 1'b1;
  logic [63:0] u_data;
  logic        seed_load = 1'b0;
  logic [63:0] seed_data = '0;
  logic [3:0]  pending;

  always #5 clk = ~clk;

  relu_mask_codec #(.WIDTH(64), .DEPTH(8), .SEED(64'h1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_mask(m_mask), .m_masked(m_masked),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .u_valid(u_valid), .u_ready(u_ready), .u_data(u_data),
    .seed_load(seed_load), .seed_data(seed_data),
    .pending(pending)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Reference: PRNG value, queue of outstanding masks, expected output regs.
  logic [63:0] ref_s;
  logic [63:0] ref_q[$];
  logic        ref_mv, ref_uv;
  logic [63:0] ref_mm, ref_mx, ref_ud;

  function automatic logic [63:0] xorshift(input logic [63:0] s);
    logic [63:0] a, b;
    a = s ^ (s << 13);
    b = a ^ (a >> 7);
    return b ^ (b << 17);
  endfunction

  task automatic ref_reset();
    ref_s = 64'h1;
    ref_q.delete();
    ref_mv = 0; ref_uv = 0;
    ref_mm = '0; ref_mx = '0; ref_ud = '0;
  endtask

  // One clock: entered and left at posedge+1, inputs already driven.
  task automatic cycle();
    logic exp_ir, exp_rr, push, pop;
    logic [63:0] head;
    @(negedge clk);
    exp_ir = (!ref_mv || m_ready) && (ref_q.size() != 8);
    exp_rr = (!ref_uv || u_ready) && (ref_q.size() != 0);
    check("in_ready", 64'(in_ready), 64'(exp_ir));
    check("r_ready",  64'(r_ready),  64'(exp_rr));
    push = in_valid && exp_ir;
    pop  = r_valid && exp_rr;
    @(posedge clk);
    if (pop) begin
      head = ref_q.pop_front();
      ref_ud = r_data - head;
      ref_uv = 1;
    end else if (u_ready) ref_uv = 0;
    if (push) begin
      ref_mm = ref_s;
      ref_mx = in_data - ref_s;
      ref_q.push_back(ref_s);
      ref_mv = 1;
    end else if (m_ready) ref_mv = 0;
    if (seed_load) ref_s = (seed_data == 0) ? 64'h1 : seed_data;
    else if (push) ref_s = xorshift(ref_s);
    #1;
    check("m_valid",  64'(m_valid), 64'(ref_mv));
    check("m_mask",   m_mask,       ref_mm);
    check("m_masked", m_masked,     ref_mx);
    check("u_valid",  64'(u_valid), 64'(ref_uv));
    check("u_data",   u_data,       ref_ud);
    check("pending",  64'(pending), 64'(ref_q.size()));
  endtask

  task automatic idle_inputs();
    in_valid = 0; r_valid = 0; seed_load = 0;
    m_ready = 1; u_ready = 1;
  endtask

  // Reset pulse entered at posedge+1; checks the asynchronous clear.
  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    #2;
    check("rst_pending",  64'(pending),  64'd0);
    check("rst_m_valid",  64'(m_valid),  64'd0);
    check("rst_u_valid",  64'(u_valid),  64'd0);
    check("rst_m_mask",   m_mask,        64'd0);
    check("rst_m_masked", m_masked,      64'd0);
    check("rst_u_data",   u_data,        64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_r_ready",  64'(r_ready),  64'd0);
    @(negedge clk);
    rst_n = 1;
    ref_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] x);
    in_valid = 1; in_data = x;
    cycle();
    in_valid = 0;
  endtask

  task automatic ret(input logic [63:0] d);
    r_valid = 1; r_data = d;
    cycle();
    r_valid = 0;
  endtask

  initial begin
    ref_reset();
    idle_inputs();
    #3;
    @(posedge clk); #1;
    do_reset();

    // First two activations from SEED = 1.
    send(64'd5);
    check("fwd0_mask",   m_mask,   64'h1);
    check("fwd0_masked", m_masked, 64'h4);
    send(64'd0);
    check("fwd1_mask",   m_mask,   64'h40822041);
    check("fwd1_masked", m_masked, 64'hFFFFFFFFBF7DDFBF);
    cycle();
    ret(64'd6);
    check("ret0_data", u_data, 64'd5);
    ret(64'h40822041);
    check("ret1_data", u_data, 64'd0);
    check("ret_pending0", 64'(pending), 64'd0);
    cycle();

    // Fill the FIFO, observe backpressure, free one slot.
    for (int i = 0; i < 8; i++) send(64'(i * 3));
    check("full_pending", 64'(pending), 64'd8);
    in_valid = 1; in_data = 64'd99;
    check("full_in_ready", 64'(in_ready), 64'd0);
    cycle();
    in_valid = 0;
    ret(64'd1234);
    check("after_pop_in_ready", 64'(in_ready), 64'd1);
    r_valid = 1;
    for (int i = 0; i < 7; i++) begin
      r_data = {$urandom, $urandom};
      cycle();
    end
    r_valid = 0;
    check("drain_pending", 64'(pending), 64'd0);
    cycle();

    // Results with nothing outstanding are refused; push is not bypassed.
    r_valid = 1; r_data = 64'hDEAD;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("empty_u_valid", 64'(u_valid), 64'd0);
    end
    in_valid = 1; in_data = 64'd77;
    cycle();
    in_valid = 0;
    check("post_push_r_ready", 64'(r_ready), 64'd1);
    cycle();
    r_valid = 0;
    cycle();

    // Forward stall: output held, in_ready low until m_ready returns.
    m_ready = 0;
    send(64'd11);
    in_valid = 1; in_data = 64'd12;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    m_ready = 1;
    cycle();
    in_valid = 0;
    cycle();

    // Return stall: two results, second held until u_ready returns.
    u_ready = 0;
    r_valid = 1; r_data = 64'h100;
    for (int i = 0; i < 4; i++) cycle();
    check("ustall_r_ready", 64'(r_ready), 64'd0);
    u_ready = 1;
    for (int i = 0; i < 3; i++) cycle();
    r_valid = 0;
    cycle();

    // Mid-operation reset discards outstanding masks; reseed behaviour.
    for (int i = 0; i < 3; i++) send(64'(100 + i));
    check("pre_rst_pending", 64'(pending), 64'd3);
    do_reset();
    send(64'd10);
    check("post_rst_mask",   m_mask,   64'h1);
    check("post_rst_masked", m_masked, 64'd9);
    seed_load = 1; seed_data = 64'd0;
    cycle();
    seed_load = 0;
    send(64'd20);
    check("seed0_mask", m_mask, 64'h1);
    seed_load = 1; seed_data = 64'd7;
    cycle();
    seed_load = 0;
    send(64'd20);
    check("seed7_mask",   m_mask,   64'h7);
    check("seed7_masked", m_masked, 64'd13);

    // Randomized traffic, including reseeds coinciding with accepts.
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = {$urandom, $urandom};
      m_ready   = ($urandom % 4) != 0;
      r_valid   = ($urandom % 3) != 0;
      r_data    = {$urandom, $urandom};
      u_ready   = ($urandom % 4) != 0;
      seed_load = ($urandom % 40) == 0;
      seed_data = (($urandom % 2) == 0) ? 64'd0 : {$urandom, $urandom};
      cycle();
    end
    idle_inputs();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/relu_mask_codec.md
# relu_mask_codec

Streaming mask codec on the client side of the masked 64-bit ReLU garbled-inference stage. Forward path: each plaintext activation x receives a fresh 64-bit additive mask g from an internal xorshift64 PRNG and is emitted as the pair (g, x − g), which is the mask/input share pair the masked ReLU consumes. Return path: each masked ReLU result relu(x) + g is unmasked by subtracting the same g, popped in order from an internal mask FIFO, yielding relu(x).

## Interface
- WIDTH, 64, datapath width; the block is specified for 64 only.
- DEPTH, 8, mask FIFO entries, power of 2, ≥2; bounds the number of outstanding activations.
- SEED, 64'h1, PRNG reset value. Must be nonzero.

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  plaintext activation valid
- in_ready  out  1  activation accepted when in_valid & in_ready
- in_data  in  64  plaintext activation x, two's complement
- m_valid  out  1  masked pair valid
- m_ready  in  1  downstream accepts masked pair
- m_mask  out  64  mask g (g_input of masked ReLU)
- m_masked  out  64  x − g mod 2^64 (e_input of masked ReLU)
- r_valid  in  1  masked ReLU result valid
- r_ready  out  1  result accepted when r_valid & r_ready
- r_data  in  64  relu(x) + g mod 2^64
- u_valid  out  1  unmasked result valid
- u_ready  in  1  downstream accepts unmasked result
- u_data  out  64  r_data − g mod 2^64 = relu(x)
- seed_load  in  1  load PRNG state this cycle
- seed_data  in  64  new PRNG state; value 0 loads SEED instead
- pending  out  log2(DEPTH)+1  number of masks in FIFO (0..DEPTH)

## Operation
- PRNG state s (64 b). Advance function: s ^= s<<13; s ^= s>>7; s ^= s<<17 (logical shifts, 64-bit).
- in_ready = (~m_valid | m_ready) & (pending != DEPTH). Combinational; no dependence on in_valid.
- Forward accept: m_mask <= s; m_masked <= in_data − s; push s into FIFO; s <= advance(s); m_valid <= 1.
- No accept and m_ready: m_valid <= 0. m_* held stable while m_valid & ~m_ready.
- r_ready = (~u_valid | u_ready) & (pending != 0).
- Return accept: u_data <= r_data − FIFO head; pop; u_valid <= 1. No accept and u_ready: u_valid <= 0.
- pending: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full: push blocked by in_ready even if a pop occurs in the same cycle. Empty: pop blocked even if a push occurs in the same cycle (no bypass).
- seed_load: s <= (seed_data == 0 ? SEED : seed_data). Overrides the advance when coinciding with a forward accept. That accept still uses the old s for masking and pushing.
- All arithmetic is modulo 2^64. Carry and borrow are discarded. No saturation, no sign handling.

## Timing
- Forward and return latency are each 1 cycle: accept at edge N, valid output after edge N.
- Full throughput (one per cycle) on each path when downstream is ready and the FIFO is not full/empty.
- A popped mask frees space for a push on the next cycle; a pushed mask is poppable on the next cycle.
- Reset (asynchronous, rst_n low): s = SEED, pending = 0, FIFO pointers 0, m_valid = 0, u_valid = 0, m_mask = m_masked = u_data = 0.
- Outputs during and right after reset: in_ready = 1, r_ready = 0.
- Reset mid-operation discards all outstanding masks. Results returned after reset for pre-reset activations are not accepted (r_ready = 0 until new pushes).

## Test plan
- Reset, SEED = 1, m_ready = 1; send in_data 5 then 0 -> m_mask = 1, m_masked = 4; then m_mask = 0x40822041, m_masked = 0xFFFFFFFFBF7DDFBF.
- Continuing: r_data = 6 then r_data = 0x40822041, u_ready = 1 -> u_data = 5 then 0, in order; pending returns to 0.
- Eight accepts with no returns (DEPTH = 8) -> pending = 8, in_ready = 0 on the 9th attempt; one return accepted -> in_ready = 1 on the next cycle.
- r_valid = 1 with pending = 0 -> r_ready = 0, u_valid stays 0 for 10 cycles; push one activation -> r_ready = 1 the following cycle.
- m_ready = 0 after one accept -> m_valid, m_mask, m_masked stable and in_ready = 0 until m_ready = 1. The same applies to u_* under u_ready = 0.
- Three activations pending, pulse rst_n low -> pending = 0, m_valid = u_valid = 0, next mask = SEED. seed_load with seed_data = 0 -> next mask = SEED; seed_data = 7 -> next mask = 7.
